// File: rtl/rsp_queue.sv
// rsp_queue: queues captured ALU results and sends them one at a time to the UART.
// A trmt/tx_done handshake paces the transfers, with a programmable idle gap after each one.
module rsp_queue #(
  parameter int DATA_W    = 14,
  parameter int RSP_W     = 16,
  parameter int DEPTH     = 4,
  parameter int EDGE_MODE = 1,
  parameter int GAP_CYC   = 8
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         snd_rsp,
  input  logic [DATA_W-1:0]            rsp_src,
  input  logic                         tx_done,
  input  logic                         clr_ovfl,
  output logic                         trmt,
  output logic [RSP_W-1:0]             tx_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovfl
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int GW = GAP_CYC > 2 ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LD = GAP_CYC > 0 ? GAP_CYC - 1 : 0;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;
  state_t state, nxt;

  logic [RSP_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [GW-1:0]    gap_cnt;
  logic             snd_q, cap, push, pop, drop, ld;

  assign cap   = EDGE_MODE != 0 ? snd_rsp & ~snd_q : snd_rsp;
  assign pop   = state == SEND;
  // a full queue still accepts a push when the head leaves in the same cycle
  assign push  = cap & (~full | pop);
  assign drop  = cap & full & ~pop;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign trmt  = state == SEND;
  assign ld    = nxt == SEND;

  always_comb begin
    nxt = state == IDLE ? (empty ? IDLE : SEND)
        : state == SEND ? WAIT
        : state == WAIT ? (tx_done ? (GAP_CYC > 0 ? GAP : IDLE) : WAIT)
        : gap_cnt != '0 ? GAP : empty ? IDLE : SEND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovfl    <= 1'b0;
      tx_data <= '0;
      gap_cnt <= '0;
      snd_q   <= 1'b0;
    end else begin
      state   <= nxt;
      snd_q   <= snd_rsp;
      wr_ptr  <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count   <= count + CW'(push) - CW'(pop);
      ovfl    <= drop | (ovfl & ~clr_ovfl);
      tx_data <= ld ? mem[rd_ptr] : tx_data;
      gap_cnt <= (state == WAIT && tx_done) ? GW'(GAP_LD)
               : (state == GAP && gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
    end
  end

  // storage needs no reset: the pointers and count define which entries are valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= RSP_W'(rsp_src);
  end
endmodule

// File: tb/tb_rsp_queue.sv
// tb_rsp_queue: directed checks of rsp_queue.
// Two instances share stimulus: a uses defaults (edge capture, gap 8); b uses level capture with gap 0.
module tb_rsp_queue;
  logic        clk = 0, rst = 1, snd_rsp = 0, tx_done = 0, clr_ovfl = 0;
  logic [13:0] rsp_src = '0;
  logic        trmt_a, full_a, empty_a, ovfl_a, trmt_b, full_b, empty_b, ovfl_b;
  logic [15:0] tx_data_a, tx_data_b;
  logic [2:0]  count_a, count_b;
  int          total = 0, bad = 0, na, nb;
  logic [15:0] da, db;

  always #5 clk = ~clk;

  rsp_queue u_a (.clk(clk), .rst(rst), .snd_rsp(snd_rsp), .rsp_src(rsp_src), .tx_done(tx_done),
    .clr_ovfl(clr_ovfl), .trmt(trmt_a), .tx_data(tx_data_a), .count(count_a), .full(full_a),
    .empty(empty_a), .ovfl(ovfl_a));

  rsp_queue #(.EDGE_MODE(0), .GAP_CYC(0)) u_b (.clk(clk), .rst(rst), .snd_rsp(snd_rsp),
    .rsp_src(rsp_src), .tx_done(tx_done), .clr_ovfl(clr_ovfl), .trmt(trmt_b), .tx_data(tx_data_b),
    .count(count_b), .full(full_b), .empty(empty_b), .ovfl(ovfl_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt_a"}, 32'(count_a), 0);
    chk({tag, "_flags_a"}, {28'd0, empty_a, full_a, ovfl_a, trmt_a}, 32'b1000);
    chk({tag, "_data_a"}, 32'(tx_data_a), 0);
    chk({tag, "_cnt_b"}, 32'(count_b), 0);
    chk({tag, "_flags_b"}, {28'd0, empty_b, full_b, ovfl_b, trmt_b}, 32'b1000);
  endtask

  task automatic push(input logic [13:0] v);
    snd_rsp = 1; rsp_src = v; tick();
    snd_rsp = 0; tick();
  endtask

  task automatic done_pulse();
    tx_done = 1; tick(); tx_done = 0;
  endtask

  // records the first cycle (relative to now) each instance asserts trmt, over 12 cycles
  task automatic watch();
    na = -1; nb = -1; da = '0; db = '0;
    for (int i = 0; i < 12; i++) begin
      if (trmt_a && na < 0) begin na = i; da = tx_data_a; end
      if (trmt_b && nb < 0) begin nb = i; db = tx_data_b; end
      tick();
    end
  endtask

  initial begin
    // reset and a single response
    tick(); tick();
    chk_reset("rst_hold");
    rst = 0; tick();
    snd_rsp = 1; rsp_src = 14'h1ABC; tick();
    snd_rsp = 0;
    chk("one_cnt", 32'(count_a), 1);
    chk("one_notrmt", 32'(trmt_a), 0);
    tick();
    chk("one_trmt", 32'(trmt_a), 1);
    chk("one_data", 32'(tx_data_a), 32'h1ABC);
    tick();
    chk("one_trmt_end", 32'(trmt_a), 0);
    chk("one_cnt0", 32'(count_a), 0);
    chk("one_hold", 32'(tx_data_a), 32'h1ABC);
    done_pulse();
    repeat (12) tick();

    // snd_rsp held high: edge vs level capture
    snd_rsp = 1;
    for (int i = 0; i < 10; i++) begin rsp_src = 14'(16'h100 + i); tick(); end
    snd_rsp = 0;
    chk("edge_cnt_a", 32'(count_a), 0);
    chk("edge_data_a", 32'(tx_data_a), 32'h100);
    chk("edge_ovfl_a", 32'(ovfl_a), 0);
    chk("lvl_cnt_b", 32'(count_b), 4);
    chk("lvl_full_b", 32'(full_b), 1);
    chk("lvl_ovfl_b", 32'(ovfl_b), 1);
    chk("lvl_data_b", 32'(tx_data_b), 32'h100);
    rst = 1; tick(); rst = 0; tick();

    // overflow with tx_done withheld, then ordered drain and gap timing
    for (int v = 1; v <= 6; v++) push(14'(v));
    chk("ov_cnt", 32'(count_a), 4);
    chk("ov_full", 32'(full_a), 1);
    chk("ov_ovfl", 32'(ovfl_a), 1);
    chk("ov_data", 32'(tx_data_a), 1);
    chk("ov_cnt_b", 32'(count_b), 4);
    for (int k = 2; k <= 5; k++) begin
      done_pulse();
      watch();
      chk($sformatf("gap8_w%0d", k), 32'(na), 8);
      chk($sformatf("data_a_w%0d", k), 32'(da), 32'(k));
      chk($sformatf("gap0_w%0d", k), 32'(nb), 1);
      chk($sformatf("data_b_w%0d", k), 32'(db), 32'(k));
    end
    chk("drain_empty", 32'(empty_a), 1);
    done_pulse();
    watch();
    chk("drain_no_trmt_a", 32'(na), 32'hFFFF_FFFF);
    chk("drain_no_trmt_b", 32'(nb), 32'hFFFF_FFFF);
    chk("drain_ovfl_kept", 32'(ovfl_a), 1);
    clr_ovfl = 1; tick(); clr_ovfl = 0;
    chk("clr_ovfl", 32'(ovfl_a), 0);

    // push while full coinciding with the SEND pop
    for (int v = 16'h70; v < 16'h75; v++) push(14'(v));
    chk("fill_full", 32'(full_a), 1);
    done_pulse();
    repeat (8) tick();
    chk("sim_trmt", 32'(trmt_a), 1);
    chk("sim_data", 32'(tx_data_a), 32'h71);
    snd_rsp = 1; rsp_src = 14'h77; tick(); snd_rsp = 0;
    chk("sim_cnt", 32'(count_a), 4);
    chk("sim_ovfl", 32'(ovfl_a), 0);
    tick();
    push(14'h88);
    chk("drop_ovfl", 32'(ovfl_a), 1);
    snd_rsp = 1; clr_ovfl = 1; rsp_src = 14'h99; tick();
    snd_rsp = 0; clr_ovfl = 0;
    chk("drop_clr_ovfl", 32'(ovfl_a), 1);
    chk("drop_cnt", 32'(count_a), 4);
    tick();
    clr_ovfl = 1; tick(); clr_ovfl = 0;
    chk("clr_only", 32'(ovfl_a), 0);

    // reset during WAIT with a full queue
    chk("pre_rst_cnt", 32'(count_a), 4);
    rst = 1; #1;
    chk_reset("rst_mid");
    rst = 0; tick();
    done_pulse();
    watch();
    chk("post_rst_no_trmt_a", 32'(na), 32'hFFFF_FFFF);
    chk("post_rst_no_trmt_b", 32'(nb), 32'hFFFF_FFFF);
    chk("post_rst_cnt", 32'(count_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
